// File: rtl/wrr_pop_scheduler_if.sv
// Queue-side and downstream-side signals of the WRR pop scheduler.
// master = scheduler, slave = FIFO bank plus downstream consumer.
interface wrr_pop_scheduler_if #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8
);
    localparam int QID_BITS = $clog2(QUEUE_QUANTITY);

    logic [QUEUE_QUANTITY-1:0]           buf_empty;
    logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data;
    logic [QUEUE_QUANTITY-1:0]           pop;
    logic [DATA_BITS-1:0]                out_data;
    logic [QID_BITS-1:0]                 out_qid;
    logic                                out_valid;
    logic                                out_ready;

    modport master (
        input  buf_empty,
        input  fifo_data,
        input  out_ready,
        output pop,
        output out_data,
        output out_qid,
        output out_valid
    );

    modport slave (
        output buf_empty,
        output fifo_data,
        output out_ready,
        input  pop,
        input  out_data,
        input  out_qid,
        input  out_valid
    );
endinterface

// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin pop scheduler over first-word-fall-through FIFOs,
// with a one-word registered output stage.
module wrr_pop_scheduler #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8,
    parameter int WEIGHT_BITS    = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enb,
    input  logic                              cfg_we,
    input  logic [$clog2(QUEUE_QUANTITY)-1:0] cfg_addr,
    input  logic [WEIGHT_BITS-1:0]            cfg_weight,
    wrr_pop_scheduler_if.master               bus
);
    localparam int QB = $clog2(QUEUE_QUANTITY);

    logic [WEIGHT_BITS-1:0]    weight [QUEUE_QUANTITY];
    logic [QB-1:0]             cur;
    logic [WEIGHT_BITS-1:0]    cnt;

    logic [QUEUE_QUANTITY-1:0] eligible;
    logic                      load;
    logic                      found;
    logic                      fire;
    logic [QB-1:0]             sel;
    logic [QB-1:0]             idx;
    logic [WEIGHT_BITS-1:0]    cnt_new;
    logic                      burst_done;
    logic [DATA_BITS-1:0]      head;

    always_comb begin
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            eligible[i] = ~bus.buf_empty[i] & (weight[i] != '0);
        end
    end

    // rst is folded in so nothing is popped during the reset cycle
    assign load = enb & (~bus.out_valid | bus.out_ready) & ~rst;

    // Descending scan so the nearest queue after cur is the last to win
    always_comb begin
        found = 1'b0;
        sel   = cur;
        idx   = cur;
        if (eligible[cur] && (cnt < weight[cur])) begin
            found = 1'b1;
        end else begin
            for (int k = QUEUE_QUANTITY - 1; k >= 1; k--) begin
                idx = cur + QB'(k);
                if (eligible[idx]) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
        end
    end

    assign fire = load & found;

    always_comb begin
        bus.pop = '0;
        if (fire) begin
            bus.pop[sel] = 1'b1;
        end
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            if (sel == QB'(i)) begin
                head = bus.fifo_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // sel equals cur only when the burst continues, so cnt+1 <= weight
    assign cnt_new    = (sel == cur) ? cnt + 1'b1 : WEIGHT_BITS'(1);
    assign burst_done = cnt_new >= weight[sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= '0;
            cnt <= '0;
        end else if (fire) begin
            if (burst_done) begin
                cur <= sel + 1'b1;
                cnt <= '0;
            end else begin
                cur <= sel;
                cnt <= cnt_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                weight[i] <= WEIGHT_BITS'(1);
            end
        end else if (cfg_we && enb) begin
            weight[cfg_addr] <= cfg_weight;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_qid   <= '0;
        end else if (fire) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= head;
            bus.out_qid   <= sel;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// Randomized and directed bench for wrr_pop_scheduler against a
// queue-level reference model.
module tb_wrr_pop_scheduler;
    localparam int QQ = 4;
    localparam int DB = 8;
    localparam int WB = 3;
    localparam int QB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enb;
    logic          cfg_we;
    logic [QB-1:0] cfg_addr;
    logic [WB-1:0] cfg_weight;

    wrr_pop_scheduler_if #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB)) bus();

    wrr_pop_scheduler #(
        .QUEUE_QUANTITY(QQ),
        .DATA_BITS(DB),
        .WEIGHT_BITS(WB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enb(enb),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_weight(cfg_weight),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int fq [QQ][$];
    int m_w [QQ];
    int m_cur, m_cnt, m_valid, m_data, m_qid;

    int dut_log [$];
    logic [QQ-1:0] last_pop;
    logic [QB-1:0] last_qid;
    logic [DB-1:0] last_data;
    logic          last_valid;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = 0; m_cnt = 0;
        m_valid = 0; m_data = 0; m_qid = 0;
        for (int i = 0; i < QQ; i++) m_w[i] = 1;
    endtask

    task automatic drive_fifo();
        logic [QQ-1:0]    e;
        logic [QQ*DB-1:0] d;
        for (int i = 0; i < QQ; i++) begin
            e[i] = (fq[i].size() == 0);
            d[i*DB +: DB] = e[i] ? 8'hEE : DB'(fq[i][0]);
        end
        bus.buf_empty = e;
        bus.fifo_data = d;
    endtask

    function automatic bit elig(int i);
        return fq[i].size() > 0 && m_w[i] != 0;
    endfunction

    task automatic step();
        int sel;
        int n;
        bit ld;
        logic [QQ-1:0] ep;
        drive_fifo();
        @(negedge clk);
        sel = -1;
        ld = enb && (!m_valid || bus.out_ready) && !rst;
        if (ld) begin
            if (elig(m_cur) && m_cnt < m_w[m_cur]) sel = m_cur;
            else begin
                for (int k = 1; k < QQ; k++) begin
                    if (sel < 0 && elig((m_cur + k) % QQ)) sel = (m_cur + k) % QQ;
                end
            end
        end
        ep = '0;
        if (sel >= 0) ep[sel] = 1'b1;
        check("pop", 32'(bus.pop), 32'(ep));
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_data", 32'(bus.out_data), 32'(m_data));
        check("out_qid", 32'(bus.out_qid), 32'(m_qid));
        last_pop = bus.pop;
        last_qid = bus.out_qid;
        last_data = bus.out_data;
        last_valid = bus.out_valid;
        if (bus.out_valid) dut_log.push_back(int'(bus.out_qid));
        if (rst) model_reset();
        else begin
            if (sel >= 0) begin
                m_valid = 1;
                m_data = fq[sel].pop_front();
                m_qid = sel;
                n = (sel == m_cur) ? m_cnt + 1 : 1;
                if (n >= m_w[sel]) begin
                    m_cur = (sel + 1) % QQ;
                    m_cnt = 0;
                end else begin
                    m_cur = sel;
                    m_cnt = n;
                end
            end else if (bus.out_ready && m_valid) m_valid = 0;
            if (cfg_we && enb) m_w[cfg_addr] = int'(cfg_weight);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill(int n);
        for (int i = 0; i < QQ; i++)
            repeat (n) fq[i].push_back(int'($urandom_range(0, 255)));
    endtask

    task automatic empty_all();
        for (int i = 0; i < QQ; i++) fq[i].delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic write_w(int a, int w);
        cfg_we = 1'b1;
        cfg_addr = QB'(a);
        cfg_weight = WB'(w);
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        logic [DB-1:0] d0;
        int exp35 [12] = '{0, 0, 0, 1, 2, 2, 0, 0, 0, 1, 2, 2};
        rst = 1'b1; enb = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_weight = '0;
        bus.out_ready = 1'b1;
        drive_fifo();
        @(posedge clk);
        #1;
        model_reset();
        step();
        rst = 1'b0;

        // plain round robin after reset
        enb = 1'b1;
        do_reset();
        fill(20);
        dut_log.delete();
        repeat (9) step();
        for (int i = 0; i < 8; i++) check("rr_seq", 32'(dut_log[i]), 32'(i % 4));

        // weights {3,1,2,0}
        empty_all();
        do_reset();
        write_w(0, 3); write_w(1, 1); write_w(2, 2); write_w(3, 0);
        fill(20);
        dut_log.delete();
        repeat (13) step();
        for (int i = 0; i < 12; i++) check("wrr_seq", 32'(dut_log[i]), 32'(exp35[i]));

        // single non-empty queue
        empty_all();
        do_reset();
        fq[2].push_back(8'h5A);
        step();
        check("q2_pop", 32'(last_pop), 32'h4);
        step();
        check("q2_qid", 32'(last_qid), 32'd2);

        // downstream stall
        do_reset();
        fill(20);
        step(); step();
        bus.out_ready = 1'b0;
        step();
        d0 = last_data;
        check("stall_pop", 32'(last_pop), 32'd0);
        repeat (4) begin
            step();
            check("stall_pop", 32'(last_pop), 32'd0);
            check("stall_data", 32'(last_data), 32'(d0));
        end
        bus.out_ready = 1'b1;
        step();
        check("resume_pop", 32'(last_pop != 0), 32'd1);

        // shrink weight mid-burst
        empty_all();
        do_reset();
        write_w(0, 4);
        fill(20);
        step(); step();
        bus.out_ready = 1'b0;
        write_w(0, 1);
        bus.out_ready = 1'b1;
        step();
        check("shrink_pop", 32'(last_pop), 32'h2);

        // reset mid-burst
        empty_all();
        do_reset();
        write_w(0, 3);
        fill(20);
        step();
        rst = 1'b1;
        step();
        check("rst_pop", 32'(last_pop), 32'd0);
        rst = 1'b0;
        step();
        check("rst_valid", 32'(last_valid), 32'd0);
        check("rst_restart", 32'(last_pop), 32'h1);
        step();
        check("rst_w1", 32'(last_pop), 32'h2);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            enb = ($urandom_range(0, 9) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            cfg_we = ($urandom_range(0, 19) == 0);
            cfg_addr = QB'($urandom_range(0, QQ - 1));
            cfg_weight = WB'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 4))
                    fq[$urandom_range(0, QQ - 1)].push_back(int'($urandom_range(0, 255)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
